// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and op classification helpers
package alu_pkg;

  localparam logic [3:0] ALU_ADD        = 4'b0000;
  localparam logic [3:0] ALU_SUB        = 4'b0001;
  localparam logic [3:0] ALU_MUL        = 4'b0010;
  localparam logic [3:0] ALU_SHL        = 4'b0011;
  localparam logic [3:0] ALU_SHR        = 4'b0100;
  localparam logic [3:0] ALU_FMUL       = 4'b0101;
  localparam logic [3:0] ALU_FFLOOR     = 4'b0110;
  localparam logic [3:0] ALU_FFLOOR_INT = 4'b0111;
  localparam logic [3:0] ALU_FCMP       = 4'b1000;
  localparam logic [3:0] ALU_ICMP       = 4'b1001;

  // FCMP result code meaning "at least one operand is NaN"
  localparam logic [1:0] FCMP_UNORDERED = 2'b11;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_FMUL);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > ALU_ICMP;
  endfunction

endpackage

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage: operand register, multi-cycle hold, result register
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [15:0]      in_imm,
  input  logic             in_use_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic             out_unordered
);

  localparam int               CNT_W    = $clog2(MUL_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  logic             s1_valid_q, s1_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic             out_zero_q, out_zero_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_illegal_q, out_illegal_d;
  logic             out_unordered_q, out_unordered_d;

  logic        s1_done, s2_free, s1_fire, accept;
  logic [31:0] b_sel;

  assign s1_done  = s1_valid_q && (cnt_q == '0);
  assign s2_free  = !out_valid_q || out_ready;
  assign s1_fire  = s1_done && s2_free;
  // out_ready reaches in_ready combinationally so a full pipe still streams
  assign in_ready = !flush && (!s1_valid_q || s1_fire);
  assign accept   = in_valid && in_ready;
  assign b_sel    = in_use_imm ? {{16{in_imm[15]}}, in_imm} : in_b;

  always_comb begin
    s1_valid_d      = s1_valid_q;
    cnt_d           = cnt_q;
    a_d             = a_q;
    b_d             = b_q;
    op_d            = op_q;
    tag_d           = tag_q;
    out_valid_d     = out_valid_q;
    out_result_d    = out_result_q;
    out_zero_d      = out_zero_q;
    out_tag_d       = out_tag_q;
    out_illegal_d   = out_illegal_q;
    out_unordered_d = out_unordered_q;

    if (flush) begin
      s1_valid_d  = 1'b0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        cnt_d      = is_multicycle(in_op) ? CNT_LOAD : '0;
        a_d        = in_a;
        b_d        = b_sel;
        op_d       = in_op;
        tag_d      = in_tag;
      end else if (s1_fire) begin
        s1_valid_d = 1'b0;
      end else if (s1_valid_q && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end

      if (s1_fire) begin
        out_valid_d     = 1'b1;
        out_result_d    = alu_result;
        out_zero_d      = alu_zero;
        out_tag_d       = tag_q;
        out_illegal_d   = is_illegal(op_q);
        out_unordered_d = (op_q == ALU_FCMP) && (alu_result == {30'd0, FCMP_UNORDERED});
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q      <= 1'b0;
      cnt_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= '0;
      tag_q           <= '0;
      out_valid_q     <= 1'b0;
      out_result_q    <= '0;
      out_zero_q      <= 1'b0;
      out_tag_q       <= '0;
      out_illegal_q   <= 1'b0;
      out_unordered_q <= 1'b0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      cnt_q           <= cnt_d;
      a_q             <= a_d;
      b_q             <= b_d;
      op_q            <= op_d;
      tag_q           <= tag_d;
      out_valid_q     <= out_valid_d;
      out_result_q    <= out_result_d;
      out_zero_q      <= out_zero_d;
      out_tag_q       <= out_tag_d;
      out_illegal_q   <= out_illegal_d;
      out_unordered_q <= out_unordered_d;
    end
  end

  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_op        = op_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign out_zero      = out_zero_q;
  assign out_tag       = out_tag_q;
  assign out_illegal   = out_illegal_q;
  assign out_unordered = out_unordered_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - bench for alu_exec_stage with a behavioural ALU beside it
module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int TAG_W   = 4;
  localparam int MUL_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, flush, in_valid, in_ready, in_use_imm, out_ready;
  logic [3:0]       in_op, alu_op;
  logic [31:0]      in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic [15:0]      in_imm;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             alu_zero, out_valid, out_zero, out_illegal, out_unordered;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0]      res;
    logic             zero;
    logic [TAG_W-1:0] tag;
    logic             ill;
    logic             unord;
  } exp_t;

  alu_exec_stage #(.TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_use_imm(in_use_imm), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_tag(out_tag), .out_illegal(out_illegal),
    .out_unordered(out_unordered)
  );

  // Stand-in for the combinational ALU; float ops are simplified but deterministic
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic nan_a, nan_b;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    case (op)
      ALU_ADD:        return a + b;
      ALU_SUB:        return a - b;
      ALU_MUL:        return a * b;
      ALU_SHL:        return a << b[4:0];
      ALU_SHR:        return a >> b[4:0];
      ALU_FMUL:       return {a[31] ^ b[31], a[30:0] ^ b[30:0]};
      ALU_FFLOOR:     return a & 32'hFFFF_0000;
      ALU_FFLOOR_INT: return a >> 16;
      ALU_FCMP: begin
        if (nan_a || nan_b) return 32'd3;
        else if (a == b) return 32'd0;
        else if ($signed(a) < $signed(b)) return 32'd1;
        else return 32'd2;
      end
      ALU_ICMP: begin
        if (a == b) return 32'd0;
        else if ($signed(a) < $signed(b)) return 32'd1;
        else return 32'd2;
      end
      default:        return 32'd0;
    endcase
  endfunction

  function automatic exp_t ref_expect(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [TAG_W-1:0] tag);
    exp_t e;
    e.res   = ref_alu(op, a, b);
    e.zero  = (e.res == 32'd0);
    e.tag   = tag;
    e.ill   = (op >= 4'd10);
    e.unord = (op == 4'd8) && (e.res == 32'd3);
    return e;
  endfunction

  always_comb begin
    alu_result = ref_alu(alu_op, alu_a, alu_b);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; in_op = 0; in_a = 0; in_b = 0;
    in_imm = 0; in_use_imm = 0; in_tag = 0;
  endtask

  task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] imm, input logic use_imm, input logic [TAG_W-1:0] tag);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_imm = imm; in_use_imm = use_imm; in_tag = tag;
  endtask

  task automatic test_reset();
    rst_n = 0; out_ready = 1; idle();
    tick(); tick();
    checks++;
    if ({out_valid, out_result, out_zero, out_tag, out_illegal, out_unordered} !== '0) begin
      errors++;
      $display("FAIL reset_out got v=%b r=%h z=%b t=%h i=%b u=%b exp all 0",
               out_valid, out_result, out_zero, out_tag, out_illegal, out_unordered);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_alu got a=%h b=%h op=%h exp 0", alu_a, alu_b, alu_op);
    end
    rst_n = 1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_add_imm();
    out_ready = 1;
    present(ALU_ADD, 32'd7, 32'd0, 16'hFFFF, 1'b1, 4'd3);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b exp 1", in_ready); end
    tick();
    idle();
    #1;
    checks++;
    if ({out_valid, alu_a, alu_b, alu_op} !== {1'b0, 32'd7, 32'hFFFF_FFFF, ALU_ADD}) begin
      errors++;
      $display("FAIL add_s1 got v=%b a=%h b=%h op=%h exp v=0 a=7 b=ffffffff op=0", out_valid, alu_a, alu_b, alu_op);
    end
    tick();
    checks++;
    if ({out_valid, out_result, out_zero, out_tag} !== {1'b1, 32'd6, 1'b0, 4'd3}) begin
      errors++;
      $display("FAIL add_out got v=%b r=%h z=%b t=%h exp v=1 r=6 z=0 t=3", out_valid, out_result, out_zero, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_multiply();
    out_ready = 1;
    present(ALU_MUL, 32'd6, 32'd7, 16'd0, 1'b0, 4'd5);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mul_accept got %b exp 1", in_ready); end
    tick();
    present(ALU_ADD, 32'd1, 32'd1, 16'd0, 1'b0, 4'd6);
    #1;
    for (int i = 0; i < MUL_LAT - 1; i++) begin
      checks++;
      if ({in_ready, out_valid, alu_a, alu_b, alu_op} !== {1'b0, 1'b0, 32'd6, 32'd7, ALU_MUL}) begin
        errors++;
        $display("FAIL mul_hold cyc=%0d got rdy=%b v=%b a=%h b=%h op=%h exp rdy=0 v=0 a=6 b=7 op=2",
                 i, in_ready, out_valid, alu_a, alu_b, alu_op);
      end
      tick();
    end
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL mul_last got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
    tick();
    idle();
    checks++;
    if ({out_valid, out_result, out_tag} !== {1'b1, 32'd42, 4'd5}) begin
      errors++;
      $display("FAIL mul_out got v=%b r=%h t=%h exp v=1 r=2a t=5", out_valid, out_result, out_tag);
    end
    tick();
    checks++;
    if ({out_valid, out_result, out_tag} !== {1'b1, 32'd2, 4'd6}) begin
      errors++;
      $display("FAIL mul_follow got v=%b r=%h t=%h exp v=1 r=2 t=6", out_valid, out_result, out_tag);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    present(ALU_SUB, 32'd10, 32'd3, 16'd0, 1'b0, 4'd1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_acc1 got %b exp 1", in_ready); end
    tick();
    present(ALU_SUB, 32'd5, 32'd5, 16'd0, 1'b0, 4'd2);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_acc2 got %b exp 1", in_ready); end
    tick();
    present(ALU_SUB, 32'd1, 32'd1, 16'd0, 1'b0, 4'd3);
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, out_valid, out_result, out_zero, out_tag} !== {1'b0, 1'b1, 32'd7, 1'b0, 4'd1}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b r=%h z=%b t=%h exp rdy=0 v=1 r=7 z=0 t=1",
                 i, in_ready, out_valid, out_result, out_zero, out_tag);
      end
      tick();
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", in_ready); end
    tick();
    idle();
    checks++;
    if ({out_valid, out_result, out_zero, out_tag} !== {1'b1, 32'd0, 1'b1, 4'd2}) begin
      errors++;
      $display("FAIL bp_second got v=%b r=%h z=%b t=%h exp v=1 r=0 z=1 t=2", out_valid, out_result, out_zero, out_tag);
    end
    tick();
    checks++;
    if ({out_valid, out_result, out_zero, out_tag} !== {1'b1, 32'd0, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL bp_third got v=%b r=%h z=%b t=%h exp v=1 r=0 z=1 t=3", out_valid, out_result, out_zero, out_tag);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_illegal_fcmp();
    out_ready = 1;
    present(4'b1100, 32'd5, 32'd9, 16'd0, 1'b0, 4'd7);
    tick();
    idle();
    tick();
    checks++;
    if ({out_valid, out_result, out_zero, out_tag, out_illegal, out_unordered} !==
        {1'b1, 32'd0, 1'b1, 4'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL illegal got v=%b r=%h z=%b t=%h i=%b u=%b exp v=1 r=0 z=1 t=7 i=1 u=0",
               out_valid, out_result, out_zero, out_tag, out_illegal, out_unordered);
    end
    present(ALU_FCMP, 32'h7FC0_0000, 32'h3F80_0000, 16'd0, 1'b0, 4'd8);
    tick();
    idle();
    tick();
    checks++;
    if ({out_valid, out_result, out_zero, out_tag, out_illegal, out_unordered} !==
        {1'b1, 32'd3, 1'b0, 4'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fcmp_nan got v=%b r=%h z=%b t=%h i=%b u=%b exp v=1 r=3 z=0 t=8 i=0 u=1",
               out_valid, out_result, out_zero, out_tag, out_illegal, out_unordered);
    end
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1;
    present(ALU_MUL, 32'd3, 32'd4, 16'd0, 1'b0, 4'd9);
    tick();
    idle();
    tick();
    flush = 1;
    present(ALU_ADD, 32'd2, 32'd2, 16'd0, 1'b0, 4'd10);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
    tick();
    idle();
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL flush_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_out cyc=%0d got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_reset_mid_op();
    out_ready = 1;
    present(ALU_MUL, 32'd9, 32'd9, 16'd0, 1'b0, 4'd11);
    tick();
    idle();
    tick();
    rst_n = 0;
    tick();
    checks++;
    if ({out_valid, out_result, out_zero, out_tag, out_illegal, out_unordered, alu_a, alu_b, alu_op} !== '0) begin
      errors++;
      $display("FAIL rst_mid got v=%b r=%h z=%b t=%h i=%b u=%b a=%h b=%h op=%h exp all 0",
               out_valid, out_result, out_zero, out_tag, out_illegal, out_unordered, alu_a, alu_b, alu_op);
    end
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_out cyc=%0d got %b exp 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a, b;
    out_ready = 1;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) present(ALU_ADD, 32'(k * 3), 32'(k + 100), 16'd0, 1'b0, 4'(k));
      else idle();
      #1;
      if (k < 6) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got %b exp 1", k, in_ready); end
      end
      if (k >= 2) begin
        a = 32'((k - 2) * 3);
        b = 32'(k - 2 + 100);
        e = ref_expect(ALU_ADD, a, b, 4'(k - 2));
        checks++;
        if ({out_valid, out_result, out_tag} !== {1'b1, e.res, e.tag}) begin
          errors++;
          $display("FAIL b2b_out k=%0d got v=%b r=%h t=%h exp v=1 r=%h t=%h", k, out_valid, out_result, out_tag, e.res, e.tag);
        end
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    exp_t sb[$];
    exp_t e, got;
    logic [31:0] a, b;
    for (int i = 0; i < 430; i++) begin
      if (i < 400) begin
        a = $urandom();
        b = $urandom();
        in_op = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a = 32'h7FC0_0000;
        if (in_op == ALU_ICMP && $urandom_range(0, 1) == 1) b = a;
        in_a = a;
        in_b = b;
        in_imm = 16'($urandom());
        in_use_imm = 1'($urandom_range(0, 1));
        in_tag = 4'(i);
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        idle();
        out_ready = 1;
      end
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rnd_spurious cyc=%0d got tag=%h exp no output", i, out_tag);
        end else begin
          e = sb.pop_front();
          got = {out_result, out_zero, out_tag, out_illegal, out_unordered};
          if (got !== e) begin
            errors++;
            $display("FAIL rnd_out cyc=%0d got r=%h z=%b t=%h i=%b u=%b exp r=%h z=%b t=%h i=%b u=%b", i,
                     got.res, got.zero, got.tag, got.ill, got.unord, e.res, e.zero, e.tag, e.ill, e.unord);
          end
        end
      end
      if (in_valid && in_ready)
        sb.push_back(ref_expect(in_op, in_a, in_use_imm ? {{16{in_imm[15]}}, in_imm} : in_b, in_tag));
      tick();
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain got pending=%0d v=%b exp pending=0 v=0", sb.size(), out_valid);
    end
  endtask

  initial begin
    rst_n = 0;
    out_ready = 1;
    idle();
    test_reset();
    test_add_imm();
    test_multiply();
    test_backpressure();
    test_illegal_fcmp();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage pipeline wrapper that sits directly upstream and downstream of the combinational ALU.
- Accepts operations from decode with a valid/ready handshake, selects operand b, and registers the ALU inputs.
- Holds those inputs stable for multi-cycle ops (integer and float multiply), then captures result/zero into an output register with its own valid/ready handshake toward writeback.

Parameters:
- TAG_W, 4, width of the instruction tag carried alongside each operation.
- MUL_LAT, 3, cycles the ALU inputs are held for ops 0010 and 0101; legal range >=1; 1 means single-cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight ops.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  stage accepts the op this cycle.
- in_op  in  4  ALU opcode.
- in_a  in  32  operand a.
- in_b  in  32  operand b (register).
- in_imm  in  16  immediate, sign-extended to 32 bits.
- in_use_imm  in  1  1: b = sext(in_imm); 0: b = in_b.
- in_tag  in  TAG_W  tag.
- alu_a, alu_b  out  32  to ALU a/b.
- alu_op  out  4  to ALU op.
- alu_result  in  32  from ALU.
- alu_zero  in  1  from ALU.
- out_valid  out  1  result register holds a valid entry.
- out_ready  in  1  writeback consumes.
- out_result  out  32  registered result.
- out_zero  out  1  registered zero flag.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  op was 1010..1111.
- out_unordered  out  1  op was 1000 and result == 3 (NaN compare).

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset: all registers to 0 (S1 valid, S2 valid, counter, alu_a/alu_b/alu_op, all out_* signals).
- S1 (operand register):
  - Loads on in_valid && in_ready.
  - alu_a/alu_b/alu_op are driven only from the S1 registers.
  - They hold their last value when S1 is empty; they never change while S1 is valid.
- Counter cnt:
  - On an S1 load, cnt = MUL_LAT-1 for op 0010/0101, else 0.
  - Decrements each cycle while S1 is valid and cnt != 0.
- s1_done = s1_valid && cnt == 0.
- s2_free = !out_valid || out_ready.
- s1_fire = s1_done && s2_free: S2 captures alu_result, alu_zero, tag, illegal, unordered; out_valid becomes 1.
- Output clear: if out_valid && out_ready && !s1_fire, out_valid becomes 0.
- in_ready = !flush && (!s1_valid || s1_fire). Combinational path from out_ready is intentional.
- Latency (accept edge to out_valid high):
  - Single-cycle ops: 1 edge, so the result is visible 2 cycles after in_valid is presented.
  - Multi-cycle ops: MUL_LAT edges.
- Throughput: 1 op/cycle for single-cycle ops with out_ready held high; no bubble on back-to-back ops.
- Backpressure:
  - out_valid && !out_ready holds S2 stable and stalls S1 once s1_done.
  - in_ready stays low until S2 drains.
- Illegal op 1010..1111: passes through normally with out_illegal = 1. The ALU returns 0, so out_result = 0 and out_zero = 1.
- flush:
  - S1 valid and out_valid go to 0; cnt goes to 0.
  - Any in_valid that cycle is not accepted.
  - flush has priority over all loads and transfers in that cycle.
- Reset mid-multiply: drops the op; no result is emitted afterwards.
- Counter width: clog2(MUL_LAT)+1. No wrap, because cnt never decrements below 0.

Decomposition:
- Shared package alu_pkg holds:
  - Op constants: ALU_ADD = 0000, ALU_SUB, ALU_MUL, ALU_SHL, ALU_SHR, ALU_FMUL, ALU_FFLOOR, ALU_FFLOOR_INT, ALU_FCMP, ALU_ICMP = 1001.
  - Function is_multicycle(op).
  - Constant FCMP_UNORDERED = 2'b11.
- No sub-module.
- The ALU is instantiated beside this stage, not inside it. The bench connects the existing alu to the alu_* ports.

Test Plan:
- Add, immediate on: op 0000, a = 7, in_imm = 16'hFFFF, use_imm = 1, out_ready = 1 -> out_result = 6, out_zero = 0, out_valid 2 cycles after presentation, in_ready stays 1.
- Multiply: op 0010, a = 6, b = 7, MUL_LAT = 3 -> in_ready low for 2 cycles, alu_a/alu_b stable, out_result = 42 after 3 edges. A following add 1+1 emerges 1 cycle later with result 2.
- Backpressure: out_ready = 0 while 3 subs (10-3, 5-5, 1-1) stream in -> first result 7 held, in_ready low after 2 accepts. Releasing out_ready yields 7, 0 (zero = 1), 0 in order with correct tags.
- Illegal op and NaN compare: op 1100 -> out_illegal = 1, result 0, zero = 1. Op 1000 with a = 32'h7FC00000, b = 32'h3F800000 -> out_result = 3, out_unordered = 1.
- Flush and reset mid-op: flush asserted on cycle 2 of a MUL_LAT = 3 multiply -> no out_valid ever for that tag, in_ready high next cycle. Repeat with rst_n = 0 -> all out_* = 0 on the next edge.
